// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and default widths, also used by instruction memory and decode.
package fetch_pkg;

  localparam int unsigned FetchAddrW = 11;
  localparam int unsigned FetchDataW = 32;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StHalted = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory port and IF/ID valid/ready slot as seen from the fetch unit.
interface fetch_if
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = FetchAddrW,
  parameter int unsigned DATA_W = FetchDataW
);

  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              if_valid;
  logic              if_ready;
  logic [DATA_W-1:0] if_instr;
  logic [ADDR_W-1:0] if_pc;

  // Fetch unit side
  modport master (
    output imem_addr,
    input  imem_rdata,
    output if_valid,
    input  if_ready,
    output if_instr,
    output if_pc
  );

  // Memory/decode side
  modport slave (
    input  imem_addr,
    output imem_rdata,
    input  if_valid,
    output if_ready,
    input  if_instr,
    input  if_pc
  );

endinterface

// File: rtl/if_id_slot.sv
// Single-entry IF/ID register: holds one instruction and its PC until decode takes it.
module if_id_slot
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = FetchAddrW,
  parameter int unsigned DATA_W = FetchDataW
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic              i_squash,
  input  logic [DATA_W-1:0] i_instr,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_instr,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_free
);

  logic              r_valid;
  logic [DATA_W-1:0] r_instr;
  logic [ADDR_W-1:0] r_pc;

  // Slot can accept a new word when empty or being drained this cycle
  always_comb begin
    o_free = !r_valid || i_ready;
  end

  // Squash beats load; a drained slot with nothing new becomes empty
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_squash) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (o_free) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, next-PC mux, run/halt FSM and accepted-instruction counter.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = FetchAddrW,
  parameter int unsigned DATA_W   = FetchDataW,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_halt_req,
  input  logic              i_redirect_valid,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  fetch_if.master           fetch_bus,
  output logic [CNT_W-1:0]  o_fetch_count,
  output logic [1:0]        o_state
);

  fetch_state_t      r_state;
  fetch_state_t      w_state_next;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;
  logic [CNT_W-1:0]  r_count;
  logic              w_slot_free;
  logic              w_fetch;
  logic              w_xfer;
  logic              w_slot_valid;

  // Next state; start together with halt_req never leaves IDLE/HALTED
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (i_start && !i_halt_req) w_state_next = StRun;
      StRun:    if (i_halt_req) w_state_next = StHalted;
      StHalted: if (i_start && !i_halt_req) w_state_next = StRun;
      default:  w_state_next = StIdle;
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

  // Fetch qualification and next PC; redirect wins over fetch in every state
  always_comb begin
    w_fetch   = (r_state == StRun) && w_slot_free && !i_redirect_valid && !i_halt_req;
    w_pc_next = r_pc;
    if (i_redirect_valid) w_pc_next = i_redirect_pc;
    else if (w_fetch)     w_pc_next = r_pc + ADDR_W'(1);
  end

  // PC register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_pc <= ADDR_W'(RESET_PC);
    else          r_pc <= w_pc_next;
  end

  // A squashed slot is not a transfer even if decode is ready
  assign w_xfer = w_slot_valid && fetch_bus.if_ready && !i_redirect_valid;

  // Count instructions accepted by decode
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)    r_count <= '0;
    else if (w_xfer) r_count <= r_count + CNT_W'(1);
  end

  if_id_slot #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_slot (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_load   (w_fetch),
    .i_squash (i_redirect_valid),
    .i_instr  (fetch_bus.imem_rdata),
    .i_pc     (r_pc),
    .i_ready  (fetch_bus.if_ready),
    .o_valid  (w_slot_valid),
    .o_instr  (fetch_bus.if_instr),
    .o_pc     (fetch_bus.if_pc),
    .o_free   (w_slot_free)
  );

  assign fetch_bus.imem_addr = r_pc;
  assign fetch_bus.if_valid  = w_slot_valid;
  assign o_fetch_count       = r_count;
  assign o_state             = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a real combinational instruction memory.
module tb_fetch_unit;

  localparam int unsigned AW = 11;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          halt_req;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          ready;
  logic [CW-1:0] fetch_count;
  logic [1:0]    state;
  logic [DW-1:0] mem [2048];

  int n_total;
  int n_bad;

  fetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  assign bus.imem_rdata = mem[bus.imem_addr];
  assign bus.if_ready   = ready;

  fetch_unit #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .RESET_PC (0),
    .CNT_W    (CW)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_start          (start),
    .i_halt_req       (halt_req),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .fetch_bus        (bus),
    .o_fetch_count    (fetch_count),
    .o_state          (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_slot(input string tag, input logic v, input logic [31:0] instr,
                            input logic [31:0] pc, input logic [31:0] cnt);
    check({tag, ".valid"}, 32'(bus.if_valid), 32'(v));
    if (v) begin
      check({tag, ".instr"}, bus.if_instr, instr);
      check({tag, ".pc"}, 32'(bus.if_pc), pc);
    end
    check({tag, ".count"}, 32'(fetch_count), cnt);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    for (int i = 0; i < 2048; i++) mem[i] = 32'hDEAD_0000 | 32'(i);
    mem[0]  = 32'h0000_2303;
    mem[1]  = 32'h0400_2023;
    mem[2]  = 32'd3;
    mem[3]  = 32'd4;
    mem[20] = 32'd20;

    rst_n = 1'b0; start = 1'b0; halt_req = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    check("rst.state", 32'(state), 0);
    check("rst.valid", 32'(bus.if_valid), 0);
    check("rst.instr", bus.if_instr, 0);
    check("rst.pc", 32'(bus.if_pc), 0);
    check("rst.count", 32'(fetch_count), 0);
    check("rst.addr", 32'(bus.imem_addr), 0);

    // Test 1: start, back-to-back fetch
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t1.state", 32'(state), 1);
    check("t1.empty", 32'(bus.if_valid), 0);
    tick();
    check_slot("t1.w0", 1'b1, 32'h0000_2303, 0, 0);
    tick();
    check_slot("t1.w1", 1'b1, 32'h0400_2023, 1, 1);

    // Test 2: stall on pc 1
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_slot("t2.hold", 1'b1, 32'h0400_2023, 1, 1);
      check("t2.addr", 32'(bus.imem_addr), 2);
    end
    ready = 1'b1;
    tick();
    check_slot("t2.rel", 1'b1, 32'd3, 2, 2);
    tick();
    check_slot("t1.w3", 1'b1, 32'd4, 3, 3);

    // Test 3: redirect to 20 squashes pending slot
    redirect_valid = 1'b1;
    redirect_pc    = 11'd20;
    tick();
    redirect_valid = 1'b0;
    check_slot("t3.squash", 1'b0, 0, 0, 3);
    check("t3.addr", 32'(bus.imem_addr), 20);
    tick();
    check_slot("t3.tgt", 1'b1, 32'd20, 20, 3);

    // Test 4: PC wrap from 2047
    redirect_valid = 1'b1;
    redirect_pc    = 11'd2047;
    tick();
    redirect_valid = 1'b0;
    check_slot("t4.squash", 1'b0, 0, 0, 3);
    tick();
    check_slot("t4.p2047", 1'b1, 32'hDEAD_07FF, 2047, 3);
    tick();
    check_slot("t4.p0", 1'b1, 32'h0000_2303, 0, 4);
    tick();
    check_slot("t4.p1", 1'b1, 32'h0400_2023, 1, 5);

    // Test 5: halt with a pending slot, drain, resume
    halt_req = 1'b1;
    ready    = 1'b0;
    tick();
    check("t5.state", 32'(state), 2);
    check_slot("t5.hold", 1'b1, 32'h0400_2023, 1, 5);
    tick();
    check_slot("t5.hold2", 1'b1, 32'h0400_2023, 1, 5);
    ready = 1'b1;
    tick();
    check_slot("t5.drain", 1'b0, 0, 0, 6);
    check("t5.addr", 32'(bus.imem_addr), 2);
    tick();
    check_slot("t5.idle", 1'b0, 0, 0, 6);
    halt_req = 1'b0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    check("t5.resume", 32'(state), 1);
    check("t5.gap", 32'(bus.if_valid), 0);
    tick();
    check_slot("t5.p2", 1'b1, 32'd3, 2, 6);
    tick();
    check_slot("t5.p3", 1'b1, 32'd4, 3, 7);

    // Test 6: mid-stream reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t6.state", 32'(state), 0);
    check("t6.valid", 32'(bus.if_valid), 0);
    check("t6.instr", bus.if_instr, 0);
    check("t6.pc", 32'(bus.if_pc), 0);
    check("t6.count", 32'(fetch_count), 0);
    check("t6.addr", 32'(bus.imem_addr), 0);

    // start with halt_req in IDLE stays IDLE; redirect in IDLE moves PC only
    start    = 1'b1;
    halt_req = 1'b1;
    tick();
    start    = 1'b0;
    halt_req = 1'b0;
    check("idle.sh", 32'(state), 0);
    redirect_valid = 1'b1;
    redirect_pc    = 11'd3;
    tick();
    redirect_valid = 1'b0;
    check("idle.addr", 32'(bus.imem_addr), 3);
    check("idle.state", 32'(state), 0);
    tick();
    check("idle.nofetch", 32'(bus.if_valid), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
